// File: rtl/jk_bank_ctrl.sv
// Command-driven bank of JK flip-flops: CLEAR/SET/TOGGLE a masked subset in
// one cycle, or run the whole bank as a synchronous binary up-counter for len cycles.

module jk_ff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_bank_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_COUNT  = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] carry;

  // Count enables: bit i toggles only when all lower bits are ones.
  assign carry[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign carry[i] = carry[i-1] & q[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_ff (.clk(clk), .reset(reset), .j(j[i]), .k(k[i]), .q(q[i]));
  end

  assign qbar = ~q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op    <= OP_CLEAR;
      mask  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_valid && cmd_ready) begin
        op   <= cmd_op;
        mask <= cmd_mask;
        rem  <= cmd_len;
      end else if (state == EXEC && rem != '0) begin
        rem <= rem - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid)
              state_nxt = (cmd_op == OP_COUNT && cmd_len == '0) ? DONE : EXEC;
      // rem <= 1 also covers a stale zero so the FSM can never stick in EXEC
      EXEC: if (op != OP_COUNT || rem <= {{(CNT_W-1){1'b0}}, 1'b1})
              state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    j         = '0;
    k         = '0;
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    if (state == EXEC) begin
      case (op)
        OP_CLEAR:  k = mask;
        OP_SET:    j = mask;
        OP_TOGGLE: begin j = mask; k = mask; end
        default:   begin j = carry; k = carry; end
      endcase
    end
  end
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: directed scenarios plus random commands
// checked against an arithmetic model of the bank value and command latency.

module tb_jk_bank_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] j, k, q, qbar;
  logic             busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  int mq     = 0;

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len),
    .j(j), .k(k), .q(q), .qbar(qbar), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, follow it to completion and check it against the model.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] m, input int len, input bit hold);
    int q0, qexp, lat, lat_exp;
    logic [7:0] jexp, kexp;
    q0 = mq;
    case (op)
      2'd0: qexp = q0 & ~int'(m);
      2'd1: qexp = q0 | int'(m);
      2'd2: qexp = q0 ^ int'(m);
      default: qexp = (q0 + len) % 256;
    endcase
    qexp    = qexp & 8'hFF;
    lat_exp = (op == 2'd3) ? ((len == 0) ? 1 : len + 1) : 2;
    jexp    = (op == 2'd1 || op == 2'd2) ? m : 8'h00;
    kexp    = (op == 2'd0 || op == 2'd2) ? m : 8'h00;

    chk("ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = m;
    cmd_len   = 8'(len);
    step();
    if (!hold) cmd_valid = 1'b0;
    cmd_op   = 2'($urandom_range(0, 3));
    cmd_mask = 8'($urandom);
    cmd_len  = 8'($urandom_range(0, 5));
    lat = 1;
    while (!done && lat < 64) begin
      chk("busy_exec", 32'(busy), 32'd1);
      if (op == 2'd3) begin
        chk("cnt_q", 32'(q), 32'((q0 + lat - 1) % 256));
        chk("cnt_jk", 32'(j ^ k), 32'd0);
        chk("cnt_j0", 32'(j[0]), 32'd1);
      end else begin
        chk("op_j", 32'(j), 32'(jexp));
        chk("op_k", 32'(k), 32'(kexp));
      end
      step();
      lat++;
    end
    chk("done_lat", 32'(lat), 32'(lat_exp));
    chk("q_done", 32'(q), 32'(qexp));
    chk("qbar_done", 32'(qbar), 32'(~qexp & 8'hFF));
    chk("busy_done", 32'(busy), 32'd1);
    chk("jk_done", 32'({j, k}), 32'd0);
    mq = qexp;
    cmd_valid = 1'b0;
    step();
    chk("done_pulse", 32'(done), 32'd0);
    chk("ready_after", 32'(cmd_ready), 32'd1);
    chk("q_hold", 32'(q), 32'(qexp));
    step();
    chk("no_extra_accept", 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_mask  = '0;
    cmd_len   = '0;
    #2;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_qbar", 32'(qbar), 32'hFF);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    mq = 0;

    run_cmd(2'd1, 8'hA5, 0, 1'b0);
    chk("set_q", 32'(q), 32'hA5);
    run_cmd(2'd2, 8'h0F, 0, 1'b1);
    chk("toggle_q", 32'(q), 32'hAA);
    run_cmd(2'd0, 8'h80, 0, 1'b1);
    chk("clear_q", 32'(q), 32'h2A);
    run_cmd(2'd0, 8'hFF, 0, 1'b0);
    run_cmd(2'd1, 8'hFE, 0, 1'b0);
    run_cmd(2'd3, 8'h00, 3, 1'b0);
    chk("count3_q", 32'(q), 32'h01);
    run_cmd(2'd3, 8'hFF, 0, 1'b0);
    chk("count0_q", 32'(q), 32'h01);

    // COUNT 10 from zero, abort with reset after four EXEC cycles
    run_cmd(2'd0, 8'hFF, 0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_len   = 8'd10;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_pre_q", 32'(q), 32'h04);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_qbar", 32'(qbar), 32'hFF);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_jk", 32'({j, k}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    step();
    chk("rel_ready", 32'(cmd_ready), 32'd1);
    chk("rel_done", 32'(done), 32'd0);
    mq = 0;
    run_cmd(2'd1, 8'h3C, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] rop;
      rop = 2'($urandom_range(0, 3));
      run_cmd(rop, 8'($urandom), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
